// File: rtl/player_ctl_if.sv
// ---------------------------------------------------------------------------
// state_pkg / player_ctl_if
//
// state_pkg    : sprite pose type shared by the controller and the drawer.
// player_ctl_if: bundle between the frame/keyboard side and the player
//                controller.
//   vblnk_in     : vertical blanking level, rising edge = frame tick
//   left/right   : horizontal move request levels
//   jump         : jump request level
//   xpos_player  : 12-bit sprite horizontal offset
//   ypos_player  : 12-bit jump height above ground
//   state        : sprite pose (IDLE / RIGHT / LEFT)
//   airborne     : high while a jump is in progress
// Modports: master drives the requests and observes the outputs,
//           slave is the controller side.
// ---------------------------------------------------------------------------
package state_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RIGHT = 2'd1,
      LEFT  = 2'd2
   } State;

endpackage : state_pkg

interface player_ctl_if;
   import state_pkg::*;

   logic        vblnk_in;
   logic        left;
   logic        right;
   logic        jump;
   logic [11:0] xpos_player;
   logic [11:0] ypos_player;
   State        state;
   logic        airborne;

   modport master (
      output vblnk_in,
      output left,
      output right,
      output jump,
      input  xpos_player,
      input  ypos_player,
      input  state,
      input  airborne
   );

   modport slave (
      input  vblnk_in,
      input  left,
      input  right,
      input  jump,
      output xpos_player,
      output ypos_player,
      output state,
      output airborne
   );

endinterface : player_ctl_if

// File: rtl/player_ctl.sv
// ---------------------------------------------------------------------------
// player_ctl
//
// Frame-rate player controller. Once per frame (rising edge of vblnk_in) the
// keyboard request levels are sampled, the sprite pose is decoded, the
// horizontal position is stepped with saturation at the screen edges and a
// three-state vertical FSM advances the jump arc. Between frame ticks every
// output holds its value.
//
// Ports:
//   clk  : pixel clock, the only clock
//   rst  : synchronous active-high reset
//   pif  : player_ctl_if.slave
//          in  : vblnk_in, left, right, jump
//          out : xpos_player, ypos_player, state, airborne (all registered)
// ---------------------------------------------------------------------------
module player_ctl
   import state_pkg::*;
#(
   parameter logic [11:0] X_INIT = 12'd492,
   parameter logic [11:0] X_MAX  = 12'd984,
   parameter logic [11:0] X_STEP = 12'd4,
   parameter logic [11:0] Y_STEP = 12'd6,
   parameter logic [11:0] JUMP_H = 12'd96
) (
   input  logic         clk,
   input  logic         rst,
   player_ctl_if.slave  pif
);

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2
   } vstate_t;

   // Saturating left step: clamps at the left screen edge.
   function automatic logic [11:0] step_left(input logic [11:0] x);
      logic [11:0] r;
      if (x < X_STEP) begin
         r = 12'd0;
      end else begin
         r = x - X_STEP;
      end
      return r;
   endfunction

   // Saturating right step: clamps at X_MAX without ever forming x + X_STEP
   // when that could exceed the legal range.
   function automatic logic [11:0] step_right(input logic [11:0] x);
      logic [11:0] r;
      if (x > (X_MAX - X_STEP)) begin
         r = X_MAX;
      end else begin
         r = x + X_STEP;
      end
      return r;
   endfunction

   // Pose decode: both or neither key pressed is treated as standing still.
   function automatic State decode_dir(input logic l, input logic r);
      State d;
      case ({l, r})
         2'b10:   d = LEFT;
         2'b01:   d = RIGHT;
         default: d = IDLE;
      endcase
      return d;
   endfunction

   // Registers
   logic        vblnk_d_r;
   logic [11:0] xpos_r;
   logic [11:0] ypos_r;
   State        state_r;
   logic        airborne_r;
   vstate_t     vstate_r;

   // Next values
   logic        tick_s;
   State        dir_s;
   logic [11:0] xpos_nxt_s;
   logic [11:0] ypos_nxt_s;
   State        state_nxt_s;
   logic        airborne_nxt_s;
   vstate_t     vstate_nxt_s;

   // One extra bit so the rise comparison cannot overflow for any parameters.
   logic [12:0] y_sum_s;

   assign tick_s  = pif.vblnk_in & ~vblnk_d_r;
   assign y_sum_s = {1'b0, ypos_r} + {1'b0, Y_STEP};

   // Horizontal position and pose: updated only on the frame tick.
   always_comb begin
      dir_s       = decode_dir(pif.left, pif.right);
      xpos_nxt_s  = xpos_r;
      state_nxt_s = state_r;
      if (tick_s) begin
         state_nxt_s = dir_s;
         case (dir_s)
            LEFT:    xpos_nxt_s = step_left(xpos_r);
            RIGHT:   xpos_nxt_s = step_right(xpos_r);
            default: xpos_nxt_s = xpos_r;
         endcase
      end else begin
         xpos_nxt_s  = xpos_r;
         state_nxt_s = state_r;
      end
   end

   // Vertical jump FSM next-state and height; jump is only looked at in
   // GROUND, so a held key relaunches on the tick after landing.
   always_comb begin
      vstate_nxt_s   = vstate_r;
      ypos_nxt_s     = ypos_r;
      airborne_nxt_s = airborne_r;
      if (tick_s) begin
         case (vstate_r)
            GROUND: begin
               if (pif.jump) begin
                  vstate_nxt_s   = RISE;
                  ypos_nxt_s     = Y_STEP;
                  airborne_nxt_s = 1'b1;
               end else begin
                  vstate_nxt_s   = GROUND;
                  ypos_nxt_s     = 12'd0;
                  airborne_nxt_s = 1'b0;
               end
            end
            RISE: begin
               airborne_nxt_s = 1'b1;
               if (y_sum_s >= {1'b0, JUMP_H}) begin
                  vstate_nxt_s = FALL;
                  ypos_nxt_s   = JUMP_H;
               end else begin
                  vstate_nxt_s = RISE;
                  ypos_nxt_s   = y_sum_s[11:0];
               end
            end
            FALL: begin
               if (ypos_r <= Y_STEP) begin
                  vstate_nxt_s   = GROUND;
                  ypos_nxt_s     = 12'd0;
                  airborne_nxt_s = 1'b0;
               end else begin
                  vstate_nxt_s   = FALL;
                  ypos_nxt_s     = ypos_r - Y_STEP;
                  airborne_nxt_s = 1'b1;
               end
            end
            default: begin
               // Unreachable encoding: recover to a safe landed state.
               vstate_nxt_s   = GROUND;
               ypos_nxt_s     = 12'd0;
               airborne_nxt_s = 1'b0;
            end
         endcase
      end else begin
         vstate_nxt_s   = vstate_r;
         ypos_nxt_s     = ypos_r;
         airborne_nxt_s = airborne_r;
      end
   end

   // State register: edge detector, position, pose and jump FSM. A tick that
   // coincides with reset is dropped because reset takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_d_r  <= 1'b0;
         xpos_r     <= X_INIT;
         ypos_r     <= 12'd0;
         state_r    <= IDLE;
         airborne_r <= 1'b0;
         vstate_r   <= GROUND;
      end else begin
         vblnk_d_r  <= pif.vblnk_in;
         xpos_r     <= xpos_nxt_s;
         ypos_r     <= ypos_nxt_s;
         state_r    <= state_nxt_s;
         airborne_r <= airborne_nxt_s;
         vstate_r   <= vstate_nxt_s;
      end
   end

   assign pif.xpos_player = xpos_r;
   assign pif.ypos_player = ypos_r;
   assign pif.state       = state_r;
   assign pif.airborne    = airborne_r;

endmodule : player_ctl

// File: tb/tb_player_ctl.sv
// ---------------------------------------------------------------------------
// tb_player_ctl
//
// Directed bench for player_ctl. Three instances share the same request
// inputs: the default one, one starting at x=2 (left-edge clamp) and one
// starting at x=982 (right-edge clamp). Expected values are hand computed.
// ---------------------------------------------------------------------------
module tb_player_ctl;
   import state_pkg::*;

   logic clk;
   logic rst;
   logic vblnk_v;
   logic left_v;
   logic right_v;
   logic jump_v;

   int vectors;
   int miscompares;

   player_ctl_if if_main ();
   player_ctl_if if_lo ();
   player_ctl_if if_hi ();

   assign if_main.vblnk_in = vblnk_v;
   assign if_main.left     = left_v;
   assign if_main.right    = right_v;
   assign if_main.jump     = jump_v;
   assign if_lo.vblnk_in   = vblnk_v;
   assign if_lo.left       = left_v;
   assign if_lo.right      = right_v;
   assign if_lo.jump       = jump_v;
   assign if_hi.vblnk_in   = vblnk_v;
   assign if_hi.left       = left_v;
   assign if_hi.right      = right_v;
   assign if_hi.jump       = jump_v;

   player_ctl u_dut (
      .clk (clk),
      .rst (rst),
      .pif (if_main.slave)
   );

   player_ctl #(.X_INIT(12'd2)) u_dut_lo (
      .clk (clk),
      .rst (rst),
      .pif (if_lo.slave)
   );

   player_ctl #(.X_INIT(12'd982)) u_dut_hi (
      .clk (clk),
      .rst (rst),
      .pif (if_hi.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One frame: vblnk high for several cycles (single tick), then low.
   task automatic frame();
      @(negedge clk) vblnk_v = 1'b1;
      repeat (4) @(negedge clk);
      vblnk_v = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst     = 1'b1;
      vblnk_v = 1'b0;
      left_v  = 1'b0;
      right_v = 1'b0;
      jump_v  = 1'b0;

      // Reset state, sampled while rst is still high
      repeat (3) @(negedge clk);
      check("rst_x",    32'(if_main.xpos_player), 32'd492);
      check("rst_y",    32'(if_main.ypos_player), 32'd0);
      check("rst_st",   32'(if_main.state),       32'(IDLE));
      check("rst_air",  32'(if_main.airborne),    32'd0);
      check("rst_x_lo", 32'(if_lo.xpos_player),   32'd2);
      check("rst_x_hi", 32'(if_hi.xpos_player),   32'd982);
      rst = 1'b0;
      @(negedge clk);

      // Left edge clamp
      left_v = 1'b1;
      frame();
      check("lft1_x",    32'(if_main.xpos_player), 32'd488);
      check("lft1_st",   32'(if_main.state),       32'(LEFT));
      check("lft1_x_lo", 32'(if_lo.xpos_player),   32'd0);
      check("lft1_stlo", 32'(if_lo.state),         32'(LEFT));
      frame();
      check("lft2_x",    32'(if_main.xpos_player), 32'd484);
      check("lft2_x_lo", 32'(if_lo.xpos_player),   32'd0);
      frame();
      check("lft3_x_lo", 32'(if_lo.xpos_player),   32'd0);
      left_v = 1'b0;

      // Right walk from reset, right edge clamp, hold between ticks
      do_reset();
      check("rst2_x", 32'(if_main.xpos_player), 32'd492);
      right_v = 1'b1;
      frame();
      check("rgt1_x",    32'(if_main.xpos_player), 32'd496);
      check("rgt1_st",   32'(if_main.state),       32'(RIGHT));
      check("rgt1_x_hi", 32'(if_hi.xpos_player),   32'd984);
      repeat (5) @(negedge clk);
      check("rgt1_hold", 32'(if_main.xpos_player), 32'd496);
      frame();
      check("rgt2_x",    32'(if_main.xpos_player), 32'd500);
      check("rgt2_x_hi", 32'(if_hi.xpos_player),   32'd984);
      frame();
      check("rgt3_x",    32'(if_main.xpos_player), 32'd504);
      check("rgt3_st",   32'(if_main.state),       32'(RIGHT));
      repeat (5) @(negedge clk);
      check("rgt3_hold", 32'(if_main.xpos_player), 32'd504);

      // Both keys: idle, no motion
      left_v = 1'b1;
      frame();
      check("both_x",  32'(if_main.xpos_player), 32'd504);
      check("both_st", 32'(if_main.state),       32'(IDLE));
      left_v  = 1'b0;
      right_v = 1'b0;
      frame();
      check("none_st", 32'(if_main.state), 32'(IDLE));

      // Single-tick jump pulse: 16 ticks up, 16 ticks down
      jump_v = 1'b1;
      frame();
      jump_v = 1'b0;
      check("jp_y1",   32'(if_main.ypos_player), 32'd6);
      check("jp_air1", 32'(if_main.airborne),    32'd1);
      for (int k = 2; k <= 32; k++) begin
         frame();
         if (k <= 16) begin
            check("jp_rise", 32'(if_main.ypos_player), 32'(6 * k));
         end else begin
            check("jp_fall", 32'(if_main.ypos_player), 32'(96 - 6 * (k - 16)));
         end
         check("jp_air", 32'(if_main.airborne), (k == 32) ? 32'd0 : 32'd1);
      end
      frame();
      check("jp_ground", 32'(if_main.ypos_player), 32'd0);

      // Held jump while walking right: restart on tick 33, not 32
      jump_v  = 1'b1;
      right_v = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         frame();
         if (k == 16) check("jh_apex", 32'(if_main.ypos_player), 32'd96);
         if (k == 32) begin
            check("jh_y32",   32'(if_main.ypos_player), 32'd0);
            check("jh_air32", 32'(if_main.airborne),    32'd0);
         end
         if (k == 33) begin
            check("jh_y33",   32'(if_main.ypos_player), 32'd6);
            check("jh_air33", 32'(if_main.airborne),    32'd1);
         end
      end
      check("jh_y48",  32'(if_main.ypos_player), 32'd48);
      check("jh_x",    32'(if_main.xpos_player), 32'd664);
      check("jh_st",   32'(if_main.state),       32'(RIGHT));

      // Reset mid-jump with a coinciding vblnk rise
      @(negedge clk);
      rst     = 1'b1;
      vblnk_v = 1'b1;
      @(posedge clk);
      #1;
      check("mr_y",   32'(if_main.ypos_player), 32'd0);
      check("mr_air", 32'(if_main.airborne),    32'd0);
      check("mr_x",   32'(if_main.xpos_player), 32'd492);
      check("mr_st",  32'(if_main.state),       32'(IDLE));
      repeat (3) @(negedge clk);
      check("mr_hold_x", 32'(if_main.xpos_player), 32'd492);

      // vblnk already high on release: first cycle ticks, then no more
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rel_x",  32'(if_main.xpos_player), 32'd496);
      check("rel_st", 32'(if_main.state),       32'(RIGHT));
      check("rel_y",  32'(if_main.ypos_player), 32'd6);
      repeat (6) @(negedge clk);
      check("rel_hold_x", 32'(if_main.xpos_player), 32'd496);
      check("rel_hold_y", 32'(if_main.ypos_player), 32'd6);
      vblnk_v = 1'b0;
      jump_v  = 1'b0;
      right_v = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_player_ctl

// File: doc/player_ctl.md
PLAYER_CTL -- requirements
Module: player_ctl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- X_INIT, 12'd492, horizontal position after reset.
- X_MAX, 12'd984, rightmost legal xpos_player (1024 minus 40 px sprite width).
- X_STEP, 12'd4, horizontal pixels moved per frame.
- Y_STEP, 12'd6, vertical pixels moved per frame while airborne.
- JUMP_H, 12'd96, jump apex height.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1, pixel clock; the only clock.
- rst, input, 1, synchronous reset, active-high.
- vblnk_in, input, 1, vertical blanking from the VGA timing chain; its rising edge defines the frame tick.
- left, input, 1, move-left request level from the keyboard decoder, synchronous to clk.
- right, input, 1, move-right request level, synchronous to clk.
- jump, input, 1, jump request level, synchronous to clk.
- xpos_player, output, 12, sprite horizontal offset for the player drawer.
- ypos_player, output, 12, jump height above ground (0 = on ground).
- state, output, State (state_pkg), sprite pose: IDLE, RIGHT or LEFT.
- airborne, output, 1, high while a jump is in progress.

Function
REQ-003 The block SHALL register vblnk_in into vblnk_d and SHALL define tick = vblnk_in & ~vblnk_d.
REQ-004 All outputs SHALL be registered, and SHALL change only on the clk edge at which tick is 1; between ticks they SHALL hold.
REQ-005 left, right and jump SHALL be sampled only in the cycle where tick is 1.
REQ-006 Direction decode at tick:
- left & ~right gives LEFT.
- right & ~left gives RIGHT.
- any other combination gives IDLE.
REQ-007 The decoded direction SHALL be written to state at tick, in the same edge as the position update.
REQ-008 Horizontal update at tick SHALL saturate, never wrap:
- LEFT: xpos = (xpos < X_STEP) ? 0 : xpos - X_STEP.
- RIGHT: xpos = (xpos > X_MAX - X_STEP) ? X_MAX : xpos + X_STEP.
- IDLE: xpos unchanged.
REQ-009 Vertical motion SHALL use a 3-state FSM {GROUND, RISE, FALL}, advanced only at tick.
REQ-010 In GROUND:
- jump=1 SHALL go to RISE with ypos = Y_STEP and airborne = 1.
- jump=0 SHALL stay in GROUND with ypos = 0.
REQ-011 In RISE:
- if ypos + Y_STEP >= JUMP_H, ypos SHALL become JUMP_H and the FSM SHALL go to FALL.
- otherwise ypos SHALL become ypos + Y_STEP.
REQ-012 In FALL:
- if ypos <= Y_STEP, ypos SHALL become 0, the FSM SHALL go to GROUND and airborne SHALL become 0.
- otherwise ypos SHALL become ypos - Y_STEP.
REQ-013 The jump input SHALL be ignored in RISE and FALL, including on the landing tick; a held jump SHALL start a new jump on the first tick after GROUND is reached.
REQ-014 Horizontal motion and state decode SHALL operate independently of the vertical FSM, including while airborne.
REQ-015 All arithmetic SHALL be 12-bit unsigned with no overflow; ypos SHALL always lie in 0..JUMP_H and xpos in 0..X_MAX.
REQ-016 vblnk_in held high for many cycles SHALL produce exactly one tick per rising edge.

Reset
REQ-017 While rst=1, at every edge:
- xpos_player = X_INIT, ypos_player = 0, state = IDLE, airborne = 0.
- FSM = GROUND, vblnk_d = 0.
REQ-018 A tick coinciding with rst=1 SHALL be discarded.
REQ-019 Reset asserted mid-jump SHALL return the FSM to GROUND with ypos = 0 on the next edge.
REQ-020 If vblnk_in=1 during the first cycle after reset release, that cycle SHALL generate a tick, because vblnk_d resets to 0.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- Reset, then right=1 for 3 vblnk rising edges: xpos 492 -> 496 -> 500 -> 504, state = RIGHT; outputs stable between edges.
- xpos = 2, left=1, one tick: xpos = 0, state = LEFT; further ticks hold xpos at 0.
- xpos = 982, right=1, one tick: xpos = 984; next tick: xpos stays 984.
- left=right=1 at tick: state = IDLE and xpos unchanged.
- jump=1 pulsed only at a single tick, defaults otherwise:
  - ypos rises 6, 12, ..., 90, 96 over 16 ticks, then falls 90, ..., 0 over 16 ticks;
  - airborne = 0 on the landing tick;
  - jump held continuously restarts on tick 33, not tick 32.
- rst asserted while ypos = 48: ypos = 0, airborne = 0, xpos = 492, state = IDLE on the next edge.
